// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - PC-side instruction fetch queue
// Issues ROM reads from prog_ctr, queues {instr, pc} and hands them to the decoder.
module instr_fetch_queue #(
  parameter int D     = 10,
  parameter int W     = 9,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  input  logic         jump_taken,
  output logic         stall,
  output logic         rom_re,
  output logic [D-1:0] rom_addr,
  input  logic [W-1:0] rom_data,
  output logic         instr_valid,
  output logic [W-1:0] instr,
  output logic [D-1:0] instr_pc,
  input  logic         instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_instr [DEPTH];
  logic [D-1:0]  mem_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [D-1:0]  inflight_pc;
  logic [CW:0]   occupancy;
  logic          enq;
  logic          deq;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reserve a slot for the read already in flight so its response always fits.
  assign occupancy   = {1'b0, count} + (CW+1)'(inflight);
  assign stall       = ~jump_taken & (occupancy >= (CW+1)'(DEPTH));
  assign rom_re      = reset & ~jump_taken & ~stall;
  assign rom_addr    = prog_ctr;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : '0;

  assign enq = inflight & ~jump_taken;
  assign deq = instr_valid & instr_ready & ~jump_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= rom_re;
      inflight_pc <= prog_ctr;
      if (jump_taken) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= bump(wr_ptr);
        if (deq) rd_ptr <= bump(rd_ptr);
        case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_instr[wr_ptr] <= rom_data;
      mem_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized self-checking bench for instr_fetch_queue
// Acts as PC and ROM; a queue-based model predicts stall, issue and delivered stream.
module tb_instr_fetch_queue;

  localparam int D     = 10;
  localparam int W     = 9;
  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [D-1:0] prog_ctr = '0;
  logic         jump_taken = 1'b0;
  logic         stall;
  logic         rom_re;
  logic [D-1:0] rom_addr;
  logic [W-1:0] rom_data = '0;
  logic         instr_valid;
  logic [W-1:0] instr;
  logic [D-1:0] instr_pc;
  logic         instr_ready = 1'b0;

  instr_fetch_queue #(.D(D), .W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_ctr    (prog_ctr),
    .jump_taken  (jump_taken),
    .stall       (stall),
    .rom_re      (rom_re),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  logic [W-1:0] rom_mem [1 << D];

  always @(posedge clk) begin
    if (rom_re) rom_data <= rom_mem[rom_addr];
  end

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // Model state: instructions waiting for the decoder, plus the fetch on the ROM bus.
  logic [D-1:0] q [$];
  logic         pend;
  logic [D-1:0] pend_pc;
  logic [D-1:0] pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend    = 1'b0;
    pend_pc = '0;
    pc      = '0;
  endtask

  // Called at a falling edge: drive one cycle, check it, advance the model past the rising edge.
  task automatic step(input logic j, input logic [D-1:0] tgt, input logic rdy);
    logic exp_stall;
    logic exp_re;
    prog_ctr    = pc;
    jump_taken  = j;
    instr_ready = rdy;
    #1;
    exp_stall = !j && ((q.size() + int'(pend)) >= DEPTH);
    exp_re    = !j && !exp_stall;
    check("stall", stall, exp_stall);
    check("rom_re", rom_re, exp_re);
    check("rom_addr", rom_addr, pc);
    check("instr_valid", instr_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("instr_pc", instr_pc, q[0]);
      check("instr", instr, rom_mem[q[0]]);
    end
    if (j) begin
      q.delete();
      pend = 1'b0;
      pc   = tgt;
    end else begin
      if (q.size() > 0 && rdy) begin
        void'(q.pop_front());
        delivered++;
      end
      if (pend) begin
        check("no_full_enqueue", q.size() >= DEPTH, 1'b0);
        q.push_back(pend_pc);
      end
      pend    = exp_re;
      pend_pc = pc;
      if (!exp_stall) pc = pc + D'(1);
    end
    @(negedge clk);
  endtask

  initial begin
    int next_jump;
    int since;
    int ready_bias;

    for (int i = 0; i < (1 << D); i++) rom_mem[i] = W'($urandom);
    model_reset();

    #1;
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, '0);
    check("rst_instr_pc", instr_pc, '0);
    check("rst_rom_re", rom_re, 1'b0);
    check("rst_stall", stall, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Streaming with the decoder always ready.
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

    // Decoder holds off: queue fills and stall holds, then drains in order.
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Single flush with entries queued.
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, D'(12'h120), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Back-to-back flushes.
    step(1'b1, D'(12'h040), 1'b1);
    step(1'b1, D'(12'h080), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Asynchronous reset between edges with the queue filled and a read in flight.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_instr_valid", instr_valid, 1'b0);
    check("async_rom_re", rom_re, 1'b0);
    check("async_stall", stall, 1'b0);
    check("async_instr", instr, '0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Random decoder readiness with periodic jumps.
    next_jump  = $urandom_range(7, 15);
    since      = 0;
    ready_bias = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 500 == 0) ready_bias = $urandom_range(0, 3);
      since++;
      if (since >= next_jump) begin
        step(1'b1, D'($urandom), $urandom_range(0, 3) >= ready_bias);
        since     = 0;
        next_jump = $urandom_range(7, 15);
      end else begin
        step(1'b0, '0, $urandom_range(0, 3) >= ready_bias);
      end
    end

    check("delivered_any", delivered > 100, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
